// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and default sizes for the down counter
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } state_e;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 4;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - ENA prescaler, one tick per PSC+1 enabled cycles
module counter_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  ena_i,
    input  logic [PRESCALE_W-1:0] psc_i,
    input  logic                  clear_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pc_q, pc_d;

    assign tick_o = ena_i && (pc_q == psc_i);

    always_comb begin
        pc_d = pc_q;
        if (clear_i || tick_o) begin
            pc_d = '0;
        end else if (ena_i) begin
            pc_d = pc_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/counter_down_reload.sv
// rtl/counter_down_reload.sv - reloadable one-shot/periodic down counter with TC pulse
// Optional ENA prescaler is compiled in with COUNTER_DOWN_PRESCALE_EN.
module counter_down_reload
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENA,
    input  logic                  LOAD,
    input  logic [WIDTH-1:0]      DATA,
    input  logic                  START,
    input  logic                  AUTO,
`ifdef COUNTER_DOWN_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] PSC,
`endif
    output logic [WIDTH-1:0]      COUNT,
    output logic                  TC,
    output logic                  BUSY
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (WIDTH < 1 || PRESCALE_W < 1) begin : g_bad_params
        $error("counter_down_reload: WIDTH and PRESCALE_W must be at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             busy_q;
    logic             tick;

`ifdef COUNTER_DOWN_PRESCALE_EN
    // The prescaler only advances while running; LOAD and START restart its phase.
    counter_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk_i   (CLK),
        .reset_i (RESET),
        .ena_i   (ENA && (state_q == RUN)),
        .psc_i   (PSC),
        .clear_i (LOAD || START),
        .tick_o  (tick)
    );
`else
    assign tick = ENA;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (LOAD) begin
            rld_d   = DATA;
            count_d = DATA;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START && count_q != '0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            // Terminal tick: never decrement past zero.
                            tc_d = 1'b1;
                            if (AUTO && rld_q != '0) begin
                                count_d = rld_q;
                            end else begin
                                count_d = '0;
                                state_d = EXPIRED;
                            end
                        end
                    end
                end
                EXPIRED: begin
                    if (START && rld_q != '0) begin
                        count_d = rld_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            count_q <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == RUN);
        end
    end

    assign COUNT = count_q;
    assign TC    = tc_q;
    assign BUSY  = busy_q;

endmodule

// File: doc/counter_down_reload.md
Name: counter_down_reload

Overview:
- Reloadable, startable WIDTH-bit down counter/timer; the counting-down counterpart to the team's reloadable up counter.
- Loads a reload value, counts down on enable ticks, and emits a one-cycle terminal-count pulse when it reaches zero.
- Runs either one-shot or auto-reload (periodic).
- Used as an interval timer / event divider beside the up counter in the lab datapath.

Parameters:
WIDTH, 8, width of DATA, COUNT and the internal reload register
PRESCALE_W, 4, width of the PSC input (used only when the optional feature is compiled in)

Ports:
CLK  input  1  clock; all state changes on rising edge
RESET  input  1  synchronous, active-high reset
ENA  input  1  count enable; one potential tick per CLK cycle
LOAD  input  1  load DATA into the reload register and COUNT
DATA  input  WIDTH  value to load
START  input  1  begin counting from the current COUNT
AUTO  input  1  1 = auto-reload at terminal count, 0 = one-shot
COUNT  output  WIDTH  current count value (registered)
TC  output  1  terminal-count pulse, exactly one cycle wide (registered)
BUSY  output  1  high while in RUN

Behaviour:
- Reset: sampled on the CLK rising edge only and overrides everything. Sets COUNT=0, reload register RLD=0, TC=0, BUSY=0, state=IDLE.
- States: IDLE (loaded or idle, not counting), RUN (counting), EXPIRED (one-shot finished). BUSY = (state==RUN), registered.
- tick = ENA (or the prescaled ENA; see Optional Feature).
- Priority per cycle: RESET > LOAD > START > tick.
- LOAD, any state: RLD<=DATA, COUNT<=DATA, state<=IDLE, TC<=0. A START or tick in the same cycle is ignored.
- IDLE:
  - START with COUNT!=0: state<=RUN. The first decrement occurs on the first tick after entering RUN.
  - START with COUNT==0: ignored; stays IDLE with no TC.
- RUN, tick with COUNT>1: COUNT<=COUNT-1.
- RUN, tick with COUNT==1: TC<=1 for one cycle, coincident with the new COUNT value.
  - If AUTO==1 and RLD!=0: COUNT<=RLD, stay in RUN. Period is exactly RLD ticks.
  - Otherwise: COUNT<=0, state<=EXPIRED.
- RUN, no tick: COUNT holds, TC=0.
- RUN, START: ignored.
- AUTO is sampled at the terminal tick only. Changing AUTO mid-run is legal.
- EXPIRED: COUNT holds 0.
  - START with RLD!=0: COUNT<=RLD, state<=RUN.
  - START with RLD==0: ignored.
  - Only LOAD or RESET returns the block to IDLE.
- Underflow is impossible: COUNT never decrements below 0 and never wraps to all-ones.
- TC is never asserted two consecutive cycles unless auto-reloading with RLD==1 and ENA held high, where TC is legitimately high every cycle.
- Reset mid-RUN: next edge shows COUNT=0, BUSY=0, and no TC pulse.

Optional Feature:
- Macro: COUNTER_DOWN_PRESCALE_EN.
- With the macro defined:
  - Adds input PSC [PRESCALE_W-1:0] and an internal prescaler counter PC.
  - tick = ENA && (PC==PSC).
  - PC increments on each ENA cycle while in RUN and clears on tick, RESET, LOAD and START.
  - PSC=0 makes every ENA cycle a tick. PSC=N makes one tick per N+1 ENA cycles.
- Without the macro: the PSC port and PC are absent, and tick = ENA.

Decomposition:
- Package counter_pkg holds:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, EXPIRED=2'b10
  - default WIDTH=8 and PRESCALE_W=4
- Optional sub-module counter_prescaler (ENA, PSC, clear → tick), instantiated only under COUNTER_DOWN_PRESCALE_EN.
- The main FSM and datapath stay in counter_down_reload.

Test Plan:
1. RESET=1 for 2 cycles while LOAD=1, DATA=8'hFF → COUNT=0, TC=0, BUSY=0 after each edge; the load is ignored.
2. LOAD DATA=8'h05, then START, with ENA=1 and AUTO=0 → COUNT goes 5,4,3,2,1,0; TC is high only in the COUNT=0 cycle; BUSY drops the same cycle; a further START reloads 5 and restarts.
3. LOAD DATA=8'h03, AUTO=1, START, ENA=1 → COUNT sequence 3,2,1,3,2,1,…; TC is high once every 3 cycles, coincident with COUNT=3 after reload.
4. RUN from 8'h04 with ENA alternating 1,0 → COUNT changes only on ENA=1 cycles; terminal count is reached after 8 cycles.
5. Mid-run at COUNT=2: assert LOAD and START together with DATA=8'hA0 → COUNT=8'hA0, BUSY=0, state IDLE, no TC; the START is ignored.
6. COUNTER_DOWN_PRESCALE_EN defined, PSC=2, LOAD 8'h02, START, ENA=1 → COUNT decrements every 3rd cycle; TC appears 6 cycles after entering RUN.
